d16_fetch: RTL and testbench

Instruction fetch stage of the d16 core. It sits directly upstream of `d16_decode`. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Fetched 32-bit instructions, tagged with their PC, are buffered in a 2-entry queue and presented to decode over a valid/ready interface. A redirect input from the execute stage (JMP/JMZ/JMR taken) flushes the queue, discards any in-flight read and restarts fetch at the target.

---
 rtl/d16_fetch_pkg.sv | 21 ++
 rtl/d16_fetch_fifo.sv | 44 ++++
 rtl/d16_fetch.sv | 104 ++++++++++
 tb/tb_d16_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d16_fetch_pkg.sv
// Shared widths, fetch queue entry layout and fetch FSM states for the d16 front end.
package d16_fetch_pkg;

  localparam int unsigned D16_PC_WIDTH    = 16;
  localparam int unsigned D16_INSTR_WIDTH = 32;

  typedef logic [D16_PC_WIDTH-1:0]    pc_t;
  typedef logic [D16_INSTR_WIDTH-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    D16_FETCH_IDLE,
    D16_FETCH_REQ,
    D16_FETCH_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/d16_fetch_fifo.sv
// Two-entry queue of fetched {instr, pc}; synchronous flush overrides push and pop.
module d16_fetch_fifo
  import d16_fetch_pkg::*;
(
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/d16_fetch.sv
// d16 instruction fetch: owns the PC, reads imem over req/ack and queues {instr, pc} for decode.
module d16_fetch
  import d16_fetch_pkg::*;
#(
  parameter pc_t RESET_PC = 16'h0000
)
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        jmp_en,
  input  logic [15:0] jmp_addr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  fetch_state_t state;
  pc_t          pc;
  logic [1:0]   count;
  logic [1:0]   count_after_pop;
  logic [1:0]   count_next;
  logic         push;
  logic         pop;
  fetch_entry_t head;

  assign pop             = instr_valid & instr_ready;
  assign push            = (state == D16_FETCH_REQ) & imem_ack & ~jmp_en;
  assign count_after_pop = count - {1'b0, pop};
  assign count_next      = count_after_pop + {1'b0, push};

  d16_fetch_fifo u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .flush     (jmp_en),
    .push      (push),
    .pop       (pop),
    .push_data ('{instr: imem_data, pc: imem_addr}),
    .head      (head),
    .count     (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // In REQ, imem_addr always equals pc, so the pushed tag is the fetched address.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= D16_FETCH_IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
    end else begin
      unique case (state)
        D16_FETCH_IDLE: begin
          if (jmp_en) begin
            pc <= jmp_addr;
          end else if (count_after_pop < 2'd2) begin
            state     <= D16_FETCH_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        D16_FETCH_REQ: begin
          if (jmp_en) begin
            pc <= jmp_addr;
            if (imem_ack) begin
              imem_addr <= jmp_addr;
            end else begin
              state <= D16_FETCH_DRAIN;
            end
          end else if (imem_ack) begin
            pc <= pc + 16'd1;
            if (count_next < 2'd2) begin
              imem_addr <= pc + 16'd1;
            end else begin
              state    <= D16_FETCH_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        D16_FETCH_DRAIN: begin
          if (jmp_en) begin
            pc <= jmp_addr;
          end
          if (imem_ack) begin
            state     <= D16_FETCH_REQ;
            imem_addr <= jmp_en ? jmp_addr : pc;
          end
        end
        default: begin
          state    <= D16_FETCH_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d16_fetch.sv
// Self-checking bench for d16_fetch: directed scenarios plus a randomized run against a PC-stream model.
module tb_d16_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        jmp_en;
  logic [15:0] jmp_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        zero_wait;
  logic        ack_man;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_ack;
  logic [31:0] w_data;
  logic        w_jmp;
  logic [15:0] w_jmp_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [15:0] w_pc;
  logic        w_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  assign imem_ack   = zero_wait ? imem_req : ack_man;
  assign imem_data  = mem_word(imem_addr);
  assign w_ack      = w_req;
  assign w_data     = mem_word(w_addr);
  assign w_jmp      = 1'b0;
  assign w_jmp_addr = 16'h0000;
  assign w_ready    = 1'b1;

  d16_fetch #(.RESET_PC(16'h0000)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  d16_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (w_ack),
    .imem_data   (w_data),
    .jmp_en      (w_jmp),
    .jmp_addr    (w_jmp_addr),
    .instr_valid (w_valid),
    .instr       (w_instr),
    .instr_pc    (w_pc),
    .instr_ready (w_ready)
  );

  task automatic do_reset();
    sys_rst     = 1'b1;
    zero_wait   = 1'b1;
    ack_man     = 1'b0;
    jmp_en      = 1'b0;
    jmp_addr    = 16'h0000;
    instr_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst     = 1'b1;
    zero_wait   = 1'b1;
    ack_man     = 1'b0;
    jmp_en      = 1'b0;
    jmp_addr    = 16'h0000;
    instr_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    vectors++; if (imem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    vectors++; if (instr_pc !== 16'h0) begin miscompares++; $display("FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
    vectors++; if (w_addr !== 16'hFFFE) begin miscompares++; $display("FAIL reset_addr_wrap: got %h expected fffe", w_addr); end
    vectors++; if (w_req !== 1'b0 || w_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wrap_req_valid: got %b%b expected 00", w_req, w_valid); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk); #1;
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'(i)) begin miscompares++; $display("FAIL zw_fetch[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, 16'(i)); end
      if (i == 0) begin
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL zw_first_valid: got %b expected 0", instr_valid); end
      end else begin
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 16'(i - 1) || instr !== mem_word(16'(i - 1))) begin miscompares++; $display("FAIL zw_deliver[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", i, instr_valid, instr_pc, instr, 16'(i - 1), mem_word(16'(i - 1))); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); #1;
      ea = 16'hFFFE + 16'(i);
      vectors++; if (w_req !== 1'b1 || w_addr !== ea) begin miscompares++; $display("FAIL wrap_fetch[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, w_req, w_addr, ea); end
      if (i > 0) begin
        vectors++; if (w_valid !== 1'b1 || w_pc !== ea - 16'd1 || w_instr !== mem_word(ea - 16'd1)) begin miscompares++; $display("FAIL wrap_deliver[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, w_valid, w_pc, ea - 16'd1); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_drop: got %b expected 0", imem_req); end
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin miscompares++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0000", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 16'(j) || instr !== mem_word(16'(j))) begin miscompares++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h expected v=1 pc=%h", j, instr_valid, instr_pc, 16'(j)); end
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic test_late_ack_jmp();
    bit found = 0;
    do_reset();
    zero_wait = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge sys_clk); #1;
      if (imem_req && imem_addr == 16'h0005) found = 1;
      else ack_man = imem_req;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL late_reach_0005: got no pending read at 0005 expected one within 40 cycles"); end
    ack_man  = 1'b0;
    jmp_en   = 1'b1;
    jmp_addr = 16'h0040;
    @(posedge sys_clk); #1;
    jmp_en = 1'b0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin miscompares++; $display("FAIL late_hold1: got req=%b addr=%h expected req=1 addr=0005", imem_req, imem_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL late_flush: got valid=%b expected 0", instr_valid); end
    @(posedge sys_clk); #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin miscompares++; $display("FAIL late_hold2: got req=%b addr=%h expected req=1 addr=0005", imem_req, imem_addr); end
    ack_man = 1'b1;
    @(posedge sys_clk); #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL late_restart: got req=%b addr=%h v=%b expected req=1 addr=0040 v=0", imem_req, imem_addr, instr_valid); end
    @(posedge sys_clk); #1;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr !== mem_word(16'h0040)) begin miscompares++; $display("FAIL late_first_target: got v=%b pc=%h expected v=1 pc=0040", instr_valid, instr_pc); end
    ack_man = 1'b0;
  endtask

  task automatic test_jmp_with_ack();
    bit found = 0;
    do_reset();
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge sys_clk); #1;
      if (imem_req && imem_addr == 16'h0007) found = 1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL jwa_reach_0007: got no read at 0007 expected one within 40 cycles"); end
    instr_ready = 1'b0;
    jmp_en      = 1'b1;
    jmp_addr    = 16'h0040;
    @(posedge sys_clk); #1;
    jmp_en = 1'b0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin miscompares++; $display("FAIL jwa_redirect: got req=%b addr=%h expected req=1 addr=0040", imem_req, imem_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL jwa_flush: got valid=%b expected 0", instr_valid); end
    instr_ready = 1'b1;
    @(posedge sys_clk); #1;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr !== mem_word(16'h0040)) begin miscompares++; $display("FAIL jwa_first_target: got v=%b pc=%h expected v=1 pc=0040", instr_valid, instr_pc); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    zero_wait = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge sys_clk); #1;
      ack_man = imem_req;
    end
    @(posedge sys_clk); #1;
    ack_man  = 1'b0;
    jmp_en   = 1'b1;
    jmp_addr = 16'h1234;
    @(posedge sys_clk); #1;
    jmp_en = 1'b0;
    #2;
    sys_rst = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin miscompares++; $display("FAIL rid_async_req_addr: got req=%b addr=%h expected req=0 addr=0000", imem_req, imem_addr); end
    vectors++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 16'h0) begin miscompares++; $display("FAIL rid_async_queue: got v=%b instr=%h pc=%h expected 0/0/0", instr_valid, instr, instr_pc); end
    ack_man = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rid_restart: got req=%b addr=%h v=%b expected req=1 addr=0000 v=0", imem_req, imem_addr, instr_valid); end
    @(posedge sys_clk); #1;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== mem_word(16'h0000)) begin miscompares++; $display("FAIL rid_first: got v=%b pc=%h expected v=1 pc=0000", instr_valid, instr_pc); end
    ack_man = 1'b0;
  endtask

  // Model: decode must see a gap-free PC stream that restarts at each redirect target.
  task automatic test_random();
    logic [15:0] exp_pc = 16'h0000;
    logic [15:0] prev_addr = 16'h0000;
    bit prev_req = 0, prev_ack = 0, prev_jmp = 0, pend = 0;
    int lat = 0, waited = 0, pops = 0;
    do_reset();
    zero_wait = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge sys_clk); #1;
      if (prev_req && !prev_ack) begin
        vectors++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin miscompares++; $display("FAIL rnd_req_hold@%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, imem_req, imem_addr, prev_addr); end
      end
      if (prev_jmp) begin
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_flush@%0d: got valid=%b expected 0", cyc, instr_valid); end
      end
      if (prev_req && prev_ack) pend = 0;
      else if (prev_req) waited++;
      instr_ready = ($urandom % 4) != 0;
      jmp_en      = ($urandom % 20) == 0;
      jmp_addr    = ($urandom % 2 != 0) ? 16'($urandom) : 16'hFFFC + 16'($urandom % 4);
      if (imem_req && !pend) begin
        pend   = 1;
        lat    = int'($urandom % 4);
        waited = 0;
      end
      ack_man = imem_req && (waited >= lat);
      #1;
      if (instr_valid && instr_ready && !jmp_en) begin
        vectors++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL rnd_stream@%0d: got pc=%h instr=%h expected pc=%h instr=%h", cyc, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 16'd1;
        pops++;
      end
      if (jmp_en) exp_pc = jmp_addr;
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      prev_jmp  = jmp_en;
    end
    jmp_en  = 1'b0;
    ack_man = 1'b0;
    vectors++; if (pops < 50) begin miscompares++; $display("FAIL rnd_progress: got %0d deliveries expected at least 50", pops); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wrap();
    test_backpressure();
    test_late_ack_jmp();
    test_jmp_with_ack();
    test_reset_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
